ans_table_ctrl: RTL and testbench
=================================

Name: ans_table_ctrl

Overview:
Frequency-table controller for the ANS coder. Loads 16 per-symbol counts from the nibble input stream and computes exclusive cumulative counts and the total with a sequential prefix pass. It then serves table read queries (count, cumulative, slot-to-symbol lookup, total) to two requesters, normally the encoder and the decoder, over one shared read port with round-robin arbitration.

Parameters:
SYM_WIDTH, 4, symbol width; table depth is 2**SYM_WIDTH = 16
CNT_WIDTH, 4, per-symbol count width
RES_WIDTH, CNT_WIDTH+SYM_WIDTH (8), width of cumulative, total, query and result

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
load_en  in  1  load mode (cmd==2'b11 decode)
load_data  in  4  count nibble
load_vld  in  1  load_data valid
load_rdy  out  1  controller accepts nibble
req0_vld / req1_vld  in  1  query request
req0_type / req1_type  in  2  00 COUNT, 01 CUM, 10 LOOKUP, 11 TOTAL
req0_query / req1_query  in  8  symbol in [3:0], or slot value for LOOKUP
req0_rdy / req1_rdy  out  1  one-cycle response strobe
req0_result / req1_result  out  8  response data, valid while rdy
table_valid  out  1  table loaded and prefix pass complete
total  out  8  sum of all counts

Behaviour:
- Reset values: all outputs 0, counts/cum/total 0, state EMPTY, rr pointer 0, load_armed 1.
- States:
  - EMPTY/READY -> LOAD when load_en=1 and load_armed. On that edge: idx=0, table_valid=0, load_armed=0.
  - load_armed returns to 1 on any cycle with load_en=0. Holding load_en high never retriggers a load.
- LOAD:
  - load_rdy=1.
  - Each load_vld&load_rdy edge writes counts[idx]=load_data and increments idx.
  - Accepting idx 15 -> PREFIX.
  - load_en=0 during LOAD aborts: -> EMPTY, table_valid=0, counts kept but unusable.
- PREFIX:
  - load_rdy=0. 16 cycles, one symbol per edge: cum[i]=acc, acc+=counts[i].
  - On the 16th edge, total=acc, state -> READY, table_valid=1.
  - table_valid rises 16 edges after the edge that accepted nibble 15.
  - load_en is ignored during PREFIX.
- Arithmetic: 8-bit unsigned with no overflow. Maximum total is 16*15 = 240.
- Query service happens only in READY. No grants in EMPTY/LOAD/PREFIX, and none on the edge that enters LOAD.
- Eligibility: a requester is eligible when its vld=1 and its rdy is not high this cycle.
- Arbitration:
  - At most one grant per cycle.
  - Both eligible: grant the requester at the rr pointer.
  - After any grant, the pointer moves to the other requester.
- Grant timing:
  - A grant on edge t registers the result.
  - reqN_rdy=1 and reqN_result are valid for exactly one cycle after edge t.
  - The other requester's rdy stays 0 and its result holds its last value.
- Requester rules: hold type/query stable until rdy. In the cycle after rdy, either drop vld or present a new request.
- Per-requester throughput is 1 every 2 cycles; alternating requesters can use the port every cycle.
- Result encoding:
  - COUNT: {4'b0, counts[q[3:0]]}.
  - CUM: cum[q[3:0]].
  - TOTAL: total.
  - LOOKUP: {4'b0, s}, where s is the largest symbol with counts[s]!=0 and cum[s]<=q. If q>=total, result = 8'hFF, which covers total=0.
- A response already granted still completes if load_en starts a new load in the next cycle.
- Async reset mid-operation clears all state; an in-flight rdy is dropped.

Test Plan:
- Reset, then idle 5 cycles -> every output 0, load_rdy=0, no rdy pulses with vld=1.
- Load counts s0=4, s1=0, s2=8, s3=4, rest 0:
  - table_valid rises 16 edges after the last nibble; total=16.
  - CUM(2)=4, CUM(3)=12.
  - LOOKUP 3->0, 5->2, 12->3, 15->3, 16->8'hFF.
- Load all counts 15 -> total=8'hF0, CUM(15)=225 (8'hE1), COUNT(7)=8'h0F, LOOKUP(239)=15.
- Both requesters hold vld continuously after reset and load:
  - Grants alternate 0,1,0,1 starting with req0.
  - Each rdy is a single-cycle pulse with the correct result; no double grant.
- Abort load after 7 nibbles (load_en=0) -> EMPTY, table_valid=0, requests unanswered.
  - Reassert load_en with 16 nibbles -> table_valid=1 with the new data.
  - Keep load_en high afterwards -> no reload.
- Assert rst_n=0 mid-PREFIX and mid-response -> all outputs 0 immediately, table_valid=0; a full reload works afterwards.

Source files
------------

// File: rtl/ans_table_ctrl.sv
// ans_table_ctrl
//   Frequency-table controller for the ANS coder. Loads one count per symbol
//   from a nibble stream, then runs a sequential prefix pass to build the
//   exclusive cumulative counts and the total. Once the table is valid it
//   answers COUNT / CUM / LOOKUP / TOTAL queries from two requesters through
//   one shared read port with round-robin arbitration.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   load_en             load mode; a rising level (load_armed) starts a load
//   load_data/vld/rdy   count nibble stream, accepted on vld & rdy
//   reqN_vld/type/query request from requester N (hold until reqN_rdy)
//   reqN_rdy/result     one-cycle response strobe and data
//   table_valid         table loaded and prefix pass complete
//   total               sum of all counts
module ans_table_ctrl #(
    parameter int SYM_WIDTH = 4,
    parameter int CNT_WIDTH = 4,
    parameter int RES_WIDTH = CNT_WIDTH + SYM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_en,
    input  logic [CNT_WIDTH-1:0] load_data,
    input  logic                 load_vld,
    output logic                 load_rdy,
    input  logic                 req0_vld,
    input  logic [1:0]           req0_type,
    input  logic [RES_WIDTH-1:0] req0_query,
    output logic                 req0_rdy,
    output logic [RES_WIDTH-1:0] req0_result,
    input  logic                 req1_vld,
    input  logic [1:0]           req1_type,
    input  logic [RES_WIDTH-1:0] req1_query,
    output logic                 req1_rdy,
    output logic [RES_WIDTH-1:0] req1_result,
    output logic                 table_valid,
    output logic [RES_WIDTH-1:0] total
);

    localparam int DEPTH = 1 << SYM_WIDTH;

    localparam logic [1:0] Q_COUNT  = 2'b00;
    localparam logic [1:0] Q_CUM    = 2'b01;
    localparam logic [1:0] Q_LOOKUP = 2'b10;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PREFIX = 2'd2,
        ST_READY  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] counts_q [DEPTH];
    logic [CNT_WIDTH-1:0] counts_d [DEPTH];
    logic [RES_WIDTH-1:0] cum_q    [DEPTH];
    logic [RES_WIDTH-1:0] cum_d    [DEPTH];
    logic [RES_WIDTH-1:0] total_q, total_d;
    logic [RES_WIDTH-1:0] acc_q, acc_d;
    logic [SYM_WIDTH-1:0] idx_q, idx_d;
    logic                 table_valid_q, table_valid_d;
    logic                 load_armed_q, load_armed_d;
    logic                 rr_q, rr_d;
    logic                 rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    logic [RES_WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;

    logic                 start_load, serve;
    logic                 elig0, elig1, gnt0, gnt1;
    logic [1:0]           sel_type;
    logic [RES_WIDTH-1:0] sel_query;
    logic [SYM_WIDTH-1:0] sel_sym, lk_sym;
    logic [RES_WIDTH-1:0] res_val;

    // A load starts only on a fresh load_en; holding it high never reloads.
    assign start_load = ((state_q == ST_EMPTY) || (state_q == ST_READY)) &&
                        load_en && load_armed_q;
    assign serve      = (state_q == ST_READY) && !start_load;

    // A requester whose strobe is up this cycle is being answered already.
    assign elig0 = req0_vld && !rdy0_q;
    assign elig1 = req1_vld && !rdy1_q;
    assign gnt0  = serve && elig0 && (!elig1 || !rr_q);
    assign gnt1  = serve && elig1 && (!elig0 ||  rr_q);

    assign sel_type  = gnt1 ? req1_type  : req0_type;
    assign sel_query = gnt1 ? req1_query : req0_query;
    assign sel_sym   = sel_query[SYM_WIDTH-1:0];

    // Slot-to-symbol: cum is non-decreasing, so the last non-empty symbol
    // whose base is <= slot owns the slot.
    always_comb begin
        lk_sym = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if ((counts_q[s] != '0) && (cum_q[s] <= sel_query)) begin
                lk_sym = SYM_WIDTH'(s);
            end
        end
    end

    always_comb begin
        res_val = total_q;
        case (sel_type)
            Q_COUNT:  res_val = {{(RES_WIDTH-CNT_WIDTH){1'b0}}, counts_q[sel_sym]};
            Q_CUM:    res_val = cum_q[sel_sym];
            Q_LOOKUP: res_val = (sel_query >= total_q) ? '1
                              : {{(RES_WIDTH-SYM_WIDTH){1'b0}}, lk_sym};
            default:  res_val = total_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        counts_d      = counts_q;
        cum_d         = cum_q;
        total_d       = total_q;
        acc_d         = acc_q;
        idx_d         = idx_q;
        table_valid_d = table_valid_q;
        load_armed_d  = load_en ? load_armed_q : 1'b1;
        rr_d          = rr_q;
        rdy0_d        = gnt0;
        rdy1_d        = gnt1;
        res0_d        = gnt0 ? res_val : res0_q;
        res1_d        = gnt1 ? res_val : res1_q;

        if (gnt0) rr_d = 1'b1;
        if (gnt1) rr_d = 1'b0;

        case (state_q)
            ST_EMPTY, ST_READY: begin
                if (start_load) begin
                    state_d       = ST_LOAD;
                    idx_d         = '0;
                    table_valid_d = 1'b0;
                    load_armed_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_vld) begin
                    counts_d[idx_q] = load_data;
                    idx_d           = idx_q + SYM_WIDTH'(1);
                end
                if (!load_en) begin
                    state_d       = ST_EMPTY;
                    table_valid_d = 1'b0;
                end else if (load_vld && (idx_q == SYM_WIDTH'(DEPTH-1))) begin
                    state_d = ST_PREFIX;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_PREFIX: begin
                cum_d[idx_q] = acc_q;
                acc_d        = acc_q + RES_WIDTH'(counts_q[idx_q]);
                idx_d        = idx_q + SYM_WIDTH'(1);
                if (idx_q == SYM_WIDTH'(DEPTH-1)) begin
                    total_d       = acc_q + RES_WIDTH'(counts_q[idx_q]);
                    state_d       = ST_READY;
                    table_valid_d = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            for (int i = 0; i < DEPTH; i++) begin
                counts_q[i] <= '0;
                cum_q[i]    <= '0;
            end
            total_q       <= '0;
            acc_q         <= '0;
            idx_q         <= '0;
            table_valid_q <= 1'b0;
            load_armed_q  <= 1'b1;
            rr_q          <= 1'b0;
            rdy0_q        <= 1'b0;
            rdy1_q        <= 1'b0;
            res0_q        <= '0;
            res1_q        <= '0;
        end else begin
            state_q       <= state_d;
            counts_q      <= counts_d;
            cum_q         <= cum_d;
            total_q       <= total_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            table_valid_q <= table_valid_d;
            load_armed_q  <= load_armed_d;
            rr_q          <= rr_d;
            rdy0_q        <= rdy0_d;
            rdy1_q        <= rdy1_d;
            res0_q        <= res0_d;
            res1_q        <= res1_d;
        end
    end

    assign load_rdy    = (state_q == ST_LOAD);
    assign req0_rdy    = rdy0_q;
    assign req1_rdy    = rdy1_q;
    assign req0_result = res0_q;
    assign req1_result = res1_q;
    assign table_valid = table_valid_q;
    assign total       = total_q;

endmodule

// File: tb/tb_ans_table_ctrl.sv
// Self-checking bench for ans_table_ctrl: directed table loads plus random
// two-requester traffic scored against a behavioural table model.
module tb_ans_table_ctrl;

    localparam logic [1:0] T_COUNT = 2'd0, T_CUM = 2'd1, T_LOOKUP = 2'd2, T_TOTAL = 2'd3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            load_en, load_vld;
    logic [3:0]      load_data;
    logic            load_rdy, table_valid;
    logic [7:0]      total;
    logic [1:0]      req_vld;
    logic [1:0][1:0] req_type;
    logic [1:0][7:0] req_query;
    logic            req0_rdy, req1_rdy;
    logic [7:0]      req0_result, req1_result;
    logic [1:0]      rdy_w;
    logic [1:0][7:0] res_w;

    int checks = 0;
    int errors = 0;
    int mcounts [16];

    assign rdy_w = {req1_rdy, req0_rdy};
    assign res_w = {req1_result, req0_result};

    always #5 clk = ~clk;

    ans_table_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .load_en(load_en), .load_data(load_data), .load_vld(load_vld), .load_rdy(load_rdy),
        .req0_vld(req_vld[0]), .req0_type(req_type[0]), .req0_query(req_query[0]),
        .req0_rdy(req0_rdy), .req0_result(req0_result),
        .req1_vld(req_vld[1]), .req1_type(req_type[1]), .req1_query(req_query[1]),
        .req1_rdy(req1_rdy), .req1_result(req1_result),
        .table_valid(table_valid), .total(total)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // ---- reference model: table semantics from the counts alone ----
    function automatic int m_total();
        int t = 0;
        for (int s = 0; s < 16; s++) t += mcounts[s];
        return t;
    endfunction

    function automatic int m_cum(input int sym);
        int t = 0;
        for (int s = 0; s < sym; s++) t += mcounts[s];
        return t;
    endfunction

    // Slot q belongs to the symbol whose interval [base, base+count) holds it.
    function automatic int m_lookup(input int q);
        int base = 0;
        if (q >= m_total()) return 255;
        for (int s = 0; s < 16; s++) begin
            if (q < base + mcounts[s]) return s;
            base += mcounts[s];
        end
        return 255;
    endfunction

    function automatic int m_result(input logic [1:0] ty, input logic [7:0] q);
        case (ty)
            T_COUNT:  return mcounts[q[3:0]];
            T_CUM:    return m_cum(int'(q[3:0]));
            T_LOOKUP: return m_lookup(int'(q));
            default:  return m_total();
        endcase
    endfunction

    function automatic void rand_counts(input int zero_pct);
        for (int s = 0; s < 16; s++)
            mcounts[s] = ($urandom_range(0, 99) < zero_pct) ? 0 : int'($urandom_range(1, 15));
    endfunction

    // ---- drivers ----
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {load_rdy, table_valid, total, req0_rdy, req1_rdy, req0_result, req1_result}, 0);
    endtask

    task automatic feed(input int n);
        int i = 0;
        int guard = 0;
        logic acc;
        load_vld  = 1'b1;
        load_data = 4'(mcounts[0]);
        while (i < n && guard < 200) begin
            @(negedge clk);
            acc = load_rdy;
            step();
            guard++;
            if (acc) begin
                i++;
                if (i < n) load_data = 4'(mcounts[i]);
            end
        end
        if (i < n) chk("feed_timeout", i, n);
    endtask

    task automatic wait_valid(input string tag);
        logic early = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k < 16 && table_valid) early = 1'b1;
        end
        chk({tag, "_tv_early"}, early, 0);
        chk({tag, "_tv_edge16"}, table_valid, 1);
        chk({tag, "_total"}, total, m_total());
    endtask

    task automatic load_table(input string tag);
        load_en = 1'b0;
        step();
        load_en = 1'b1;
        feed(16);
        load_vld = 1'b0;
        wait_valid(tag);
    endtask

    task automatic query(input int n, input logic [1:0] ty, input logic [7:0] q,
                         output logic [7:0] res);
        int t = 0;
        req_type[n] = ty; req_query[n] = q; req_vld[n] = 1'b1;
        do begin @(negedge clk); t++; end while (!rdy_w[n] && t < 40);
        res = res_w[n];
        if (!rdy_w[n]) chk("query_timeout", 0, 1);
        step();
        req_vld[n] = 1'b0;
    endtask

    task automatic dq(input string tag, input int n, input logic [1:0] ty,
                      input logic [7:0] q, input int exp);
        logic [7:0] r;
        query(n, ty, q, r);
        chk(tag, r, exp);
        chk({tag, "_model"}, r, m_result(ty, q));
    endtask

    task automatic run_req(input int n, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            int gap;
            int t;
            logic [1:0] ty;
            logic [7:0] q;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                req_vld[n] = 1'b0;
                repeat (gap) step();
            end
            ty = 2'($urandom_range(0, 3));
            q  = (ty == T_LOOKUP) ? 8'($urandom_range(0, m_total() + 3)) : 8'($urandom);
            req_type[n] = ty; req_query[n] = q; req_vld[n] = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!rdy_w[n] && t < 40);
            if (!rdy_w[n]) chk("rnd_timeout", 0, 1);
            else chk("rnd_res", res_w[n], m_result(ty, q));
            step();
        end
        req_vld[n] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst_n = 1'b0; load_en = 1'b0; load_vld = 1'b0; load_data = '0;
        req_vld = '0; req_type = '0; req_query = '0;
        for (int s = 0; s < 16; s++) mcounts[s] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle in EMPTY with both requesters asking: nothing answers.
        req_vld = 2'b11; req_type = {T_TOTAL, T_COUNT};
        repeat (5) begin @(negedge clk); check_zero("reset_idle"); end
        step();
        req_vld = '0;

        // Sparse table.
        mcounts = '{4, 0, 8, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        load_table("sparse");
        chk("sparse_total16", total, 16);
        dq("cum2",  0, T_CUM, 8'd2, 4);
        dq("cum3",  1, T_CUM, 8'd3, 12);
        dq("lk3",   0, T_LOOKUP, 8'd3, 0);
        dq("lk5",   1, T_LOOKUP, 8'd5, 2);
        dq("lk12",  0, T_LOOKUP, 8'd12, 3);
        dq("lk15",  1, T_LOOKUP, 8'd15, 3);
        dq("lk16",  0, T_LOOKUP, 8'd16, 8'hFF);

        // Full table.
        for (int s = 0; s < 16; s++) mcounts[s] = 15;
        load_table("full");
        chk("full_total", total, 8'hF0);
        dq("cum15",  0, T_CUM, 8'd15, 8'hE1);
        dq("cnt7",   1, T_COUNT, 8'd7, 8'h0F);
        dq("lk239",  0, T_LOOKUP, 8'd239, 15);
        dq("tot",    1, T_TOTAL, 8'd0, 8'hF0);

        // Aborted load leaves the table unusable.
        load_en = 1'b0; step();
        load_en = 1'b1;
        feed(7);
        load_en = 1'b0; load_vld = 1'b0;
        step();
        chk("abort_tv", table_valid, 0);
        chk("abort_load_rdy", load_rdy, 0);
        req_vld = 2'b11; seen = 1'b0;
        repeat (6) begin @(negedge clk); if (req0_rdy || req1_rdy) seen = 1'b1; end
        chk("abort_no_resp", seen, 0);
        step(); req_vld = '0;
        rand_counts(25);
        load_table("reload");
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (load_rdy || !table_valid) seen = 1'b1; end
        chk("no_retrigger", seen, 0);
        step();
        dq("reload_cnt", 1, T_COUNT, 8'd5, mcounts[5]);

        // Reset in the middle of the prefix pass.
        load_en = 1'b0; step();
        load_en = 1'b1;
        feed(16);
        load_vld = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("rst_prefix");
        load_en = 1'b0;
        step(); rst_n = 1'b1;
        step();
        chk("rst_prefix_tv", table_valid, 0);

        // Reset while a response strobe is up.
        rand_counts(20);
        load_table("pre_rst");
        req_type[0] = T_TOTAL; req_query[0] = '0; req_vld[0] = 1'b1;
        begin
            int t = 0;
            do begin @(negedge clk); t++; end while (!req0_rdy && t < 10);
            chk("pre_rst_rdy", req0_rdy, 1);
        end
        #2 rst_n = 1'b0;
        #1 check_zero("rst_resp");
        req_vld = '0; load_en = 1'b0;
        step(); rst_n = 1'b1;

        // Fresh load after reset; both hold vld -> strict alternation from req0.
        rand_counts(20);
        load_table("alt");
        req_type[0] = T_TOTAL; req_query[0] = '0;
        req_type[1] = T_CUM;   req_query[1] = 8'($urandom_range(0, 15));
        req_vld = 2'b11;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("alt_rdy", rdy_w, (k % 2 == 1) ? 2'b01 : 2'b10);
            if (k % 2 == 1) chk("alt_res0", req0_result, m_total());
            else            chk("alt_res1", req1_result, m_result(T_CUM, req_query[1]));
            @(posedge clk);
        end
        #1 req_vld = '0;
        repeat (3) step();

        // Random concurrent traffic over two random tables.
        for (int r = 0; r < 2; r++) begin
            rand_counts(30);
            load_table("rnd");
            fork
                run_req(0, 25);
                run_req(1, 25);
            join
            repeat (2) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
